dmem_bridge: RTL and testbench

Data-memory bridge sitting directly downstream of the processor datapath. It takes the datapath's single-cycle load/store request (ALU result as address, register read port 2 as store data) and runs it as a req/ack transaction on a variable-latency memory bus. While the transaction is in flight it stalls the processor, then returns load data on `readdata`. It also rejects misaligned word accesses and aborts bus transactions that time out.

---
 rtl/dmem_bridge_if.sv | 35 +++
 rtl/dmem_bridge.sv | 116 +++++++++++
 tb/tb_dmem_bridge.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// ---------------------------------------------------------------------------
// dmem_bridge_if: datapath-side request/response and memory-bus signal bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dmem_bridge_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  // Bridge side: drives the datapath responses and the bus request.
  modport master (
    input  memread, memwrite, aluout, writedata, bus_ack, bus_rdata,
    output readdata, stall, err, bus_req, bus_we, bus_addr, bus_wdata
  );

  // Environment side: datapath plus memory slave.
  modport slave (
    output memread, memwrite, aluout, writedata, bus_ack, bus_rdata,
    input  readdata, stall, err, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge: runs datapath load/store as a req/ack bus transaction, stalling
// the core while in flight; flags misaligned accesses and bus timeouts.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  dmem_bridge_if.master mif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        tout_q, tout_d;

  logic        req_w;
  logic        aligned_w;

  assign req_w     = mif.memread | mif.memwrite;
  assign aligned_w = (mif.aluout[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    tout_d  = tout_q;
    case (state_q)
      S_IDLE: begin
        if (req_w && aligned_w) begin
          addr_d  = mif.aluout;
          wdata_d = mif.writedata;
          we_d    = mif.memwrite;
          cnt_d   = 8'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Ack is checked first so a reply in the last allowed cycle beats the timeout.
        if (mif.bus_ack) begin
          state_d = S_DONE;
          tout_d  = 1'b0;
          if (!we_q) begin
            rdata_d = mif.bus_rdata;
          end
        end else if (cnt_q == LAST_WAIT) begin
          state_d = S_DONE;
          tout_d  = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mif.bus_req   = (state_q == S_REQ);
    mif.bus_we    = (state_q == S_REQ) & we_q;
    mif.bus_wdata = (state_q == S_REQ) ? wdata_q : 32'd0;
    mif.bus_addr  = addr_q;
    mif.readdata  = (state_q == S_DONE) ? rdata_q : 32'd0;
    mif.stall     = ~reset & (((state_q == S_IDLE) & req_w & aligned_w) |
                              (state_q == S_REQ));
    mif.err       = ~reset & (((state_q == S_IDLE) & req_w & ~aligned_w) |
                              ((state_q == S_DONE) & tout_q));
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_bridge: directed self-checking bench for dmem_bridge (TIMEOUT=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_bridge;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  dmem_bridge_if mif ();

  dmem_bridge #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mif.memread = 1'b1;
    mif.aluout  = 32'h10;
    tick();
    tick();
    #3;
    total++; if (mif.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", mif.stall); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", mif.err); end
    total++; if (mif.bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%b want=0", mif.bus_req); end
    total++; if (mif.bus_we !== 1'b0) begin bad++; $display("FAIL reset_bus_we got=%b want=0", mif.bus_we); end
    total++; if (mif.bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got=%h want=0", mif.bus_addr); end
    total++; if (mif.bus_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus_wdata got=%h want=0", mif.bus_wdata); end
    total++; if (mif.readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h want=0", mif.readdata); end
    tick();
    reset = 1'b0;
    mif.memread = 1'b0;
  endtask

  task automatic test_load;
    mif.memread = 1'b1;
    mif.aluout  = 32'h10;
    #3;
    total++; if (mif.stall !== 1'b1) begin bad++; $display("FAIL load_idle_stall got=%b want=1", mif.stall); end
    total++; if (mif.bus_req !== 1'b0) begin bad++; $display("FAIL load_idle_req got=%b want=0", mif.bus_req); end
    tick();
    mif.bus_ack   = 1'b1;
    mif.bus_rdata = 32'hCAFE_F00D;
    #3;
    total++; if (mif.bus_req !== 1'b1) begin bad++; $display("FAIL load_req got=%b want=1", mif.bus_req); end
    total++; if (mif.bus_addr !== 32'h10) begin bad++; $display("FAIL load_addr got=%h want=00000010", mif.bus_addr); end
    total++; if (mif.bus_we !== 1'b0) begin bad++; $display("FAIL load_we got=%b want=0", mif.bus_we); end
    total++; if (mif.stall !== 1'b1) begin bad++; $display("FAIL load_req_stall got=%b want=1", mif.stall); end
    tick();
    mif.bus_ack = 1'b0;
    #3;
    total++; if (mif.readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL load_readdata got=%h want=cafef00d", mif.readdata); end
    total++; if (mif.stall !== 1'b0) begin bad++; $display("FAIL load_done_stall got=%b want=0", mif.stall); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL load_done_err got=%b want=0", mif.err); end
    tick();
    mif.memread = 1'b0;
    #3;
    total++; if (mif.readdata !== 32'h0) begin bad++; $display("FAIL load_idle_readdata got=%h want=0", mif.readdata); end
    tick();
  endtask

  task automatic test_store;
    int stall_cycles;
    stall_cycles = 0;
    mif.memwrite  = 1'b1;
    mif.aluout    = 32'h20;
    mif.writedata = 32'h1234_5678;
    #3;
    if (mif.stall === 1'b1) stall_cycles++;
    for (int i = 0; i < 4; i++) begin
      tick();
      mif.bus_ack = (i == 3);
      #3;
      if (mif.stall === 1'b1) stall_cycles++;
      total++; if (mif.bus_req !== 1'b1) begin bad++; $display("FAIL store_req[%0d] got=%b want=1", i, mif.bus_req); end
      total++; if (mif.bus_we !== 1'b1) begin bad++; $display("FAIL store_we[%0d] got=%b want=1", i, mif.bus_we); end
      total++; if (mif.bus_wdata !== 32'h1234_5678) begin bad++; $display("FAIL store_wdata[%0d] got=%h want=12345678", i, mif.bus_wdata); end
      total++; if (mif.bus_addr !== 32'h20) begin bad++; $display("FAIL store_addr[%0d] got=%h want=00000020", i, mif.bus_addr); end
    end
    tick();
    mif.bus_ack  = 1'b0;
    mif.memwrite = 1'b0;
    #3;
    if (mif.stall === 1'b1) stall_cycles++;
    total++; if (stall_cycles !== 5) begin bad++; $display("FAIL store_stall_cycles got=%0d want=5", stall_cycles); end
    total++; if (mif.bus_req !== 1'b0) begin bad++; $display("FAIL store_done_req got=%b want=0", mif.bus_req); end
    total++; if (mif.bus_we !== 1'b0 || mif.bus_wdata !== 32'h0) begin bad++; $display("FAIL store_done_bus got=%b/%h want=0/0", mif.bus_we, mif.bus_wdata); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL store_done_err got=%b want=0", mif.err); end
    tick();
  endtask

  task automatic test_misaligned;
    mif.memread = 1'b1;
    mif.aluout  = 32'h22;
    #3;
    total++; if (mif.err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b want=1", mif.err); end
    total++; if (mif.stall !== 1'b0) begin bad++; $display("FAIL mis_stall got=%b want=0", mif.stall); end
    total++; if (mif.bus_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b want=0", mif.bus_req); end
    total++; if (mif.readdata !== 32'h0) begin bad++; $display("FAIL mis_readdata got=%h want=0", mif.readdata); end
    tick();
    mif.memread = 1'b0;
    #3;
    total++; if (mif.err !== 1'b0 || mif.bus_req !== 1'b0) begin bad++; $display("FAIL mis_after got=%b/%b want=0/0", mif.err, mif.bus_req); end
    tick();
  endtask

  task automatic test_timeout;
    mif.memread = 1'b1;
    mif.aluout  = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      #3;
      total++; if (mif.bus_req !== 1'b1 || mif.err !== 1'b0) begin bad++; $display("FAIL tout_req[%0d] got=%b/%b want=1/0", i, mif.bus_req, mif.err); end
    end
    tick();
    mif.memread = 1'b0;
    #3;
    total++; if (mif.err !== 1'b1) begin bad++; $display("FAIL tout_err got=%b want=1", mif.err); end
    total++; if (mif.readdata !== 32'h0) begin bad++; $display("FAIL tout_readdata got=%h want=0", mif.readdata); end
    total++; if (mif.bus_req !== 1'b0 || mif.stall !== 1'b0) begin bad++; $display("FAIL tout_done got=%b/%b want=0/0", mif.bus_req, mif.stall); end
    tick();
    #3;
    total++; if (mif.err !== 1'b0 || mif.bus_req !== 1'b0) begin bad++; $display("FAIL tout_idle got=%b/%b want=0/0", mif.err, mif.bus_req); end
    // Same request, but the slave answers in the last allowed cycle.
    mif.memread   = 1'b1;
    mif.aluout    = 32'h44;
    mif.bus_rdata = 32'hA5A5_5A5A;
    for (int i = 0; i < 4; i++) begin
      tick();
      mif.bus_ack = (i == 3);
      #3;
      total++; if (mif.bus_req !== 1'b1) begin bad++; $display("FAIL late_req[%0d] got=%b want=1", i, mif.bus_req); end
    end
    tick();
    mif.bus_ack = 1'b0;
    mif.memread = 1'b0;
    #3;
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL late_err got=%b want=0", mif.err); end
    total++; if (mif.readdata !== 32'hA5A5_5A5A) begin bad++; $display("FAIL late_readdata got=%h want=a5a55a5a", mif.readdata); end
    tick();
  endtask

  task automatic test_reset_mid;
    mif.memread = 1'b1;
    mif.aluout  = 32'h30;
    tick();
    tick();
    #3;
    total++; if (mif.bus_req !== 1'b1) begin bad++; $display("FAIL rmid_req2 got=%b want=1", mif.bus_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mif.memread   = 1'b0;
    mif.bus_ack   = 1'b1;
    mif.bus_rdata = 32'hBAD0_BAD0;
    #3;
    total++; if (mif.bus_req !== 1'b0 || mif.stall !== 1'b0) begin bad++; $display("FAIL rmid_after got=%b/%b want=0/0", mif.bus_req, mif.stall); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b want=0", mif.err); end
    tick();
    mif.bus_ack = 1'b0;
    #3;
    total++; if (mif.bus_req !== 1'b0 || mif.readdata !== 32'h0 || mif.err !== 1'b0) begin bad++; $display("FAIL rmid_ack_ignored got=%b/%h/%b want=0/0/0", mif.bus_req, mif.readdata, mif.err); end
    mif.memread = 1'b1;
    mif.aluout  = 32'h34;
    tick();
    mif.bus_ack   = 1'b1;
    mif.bus_rdata = 32'h1122_3344;
    #3;
    total++; if (mif.bus_addr !== 32'h34) begin bad++; $display("FAIL rmid_next_addr got=%h want=00000034", mif.bus_addr); end
    tick();
    mif.bus_ack = 1'b0;
    mif.memread = 1'b0;
    #3;
    total++; if (mif.readdata !== 32'h1122_3344) begin bad++; $display("FAIL rmid_next_data got=%h want=11223344", mif.readdata); end
    tick();
  endtask

  task automatic test_both;
    mif.memread   = 1'b1;
    mif.memwrite  = 1'b1;
    mif.aluout    = 32'h50;
    mif.writedata = 32'hDEAD_BEEF;
    tick();
    mif.bus_ack = 1'b1;
    #3;
    total++; if (mif.bus_we !== 1'b1) begin bad++; $display("FAIL both_we got=%b want=1", mif.bus_we); end
    total++; if (mif.bus_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL both_wdata got=%h want=deadbeef", mif.bus_wdata); end
    tick();
    mif.bus_ack  = 1'b0;
    mif.memread  = 1'b0;
    mif.memwrite = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    mif.memread = 1'b1;
    mif.aluout  = 32'h60;
    tick();
    mif.bus_ack   = 1'b1;
    mif.bus_rdata = 32'h0000_0001;
    tick();
    mif.bus_ack = 1'b0;
    mif.aluout  = 32'h64;
    #3;
    total++; if (mif.readdata !== 32'h1) begin bad++; $display("FAIL b2b_first_data got=%h want=00000001", mif.readdata); end
    total++; if (mif.bus_req !== 1'b0 || mif.stall !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b/%b want=0/0", mif.bus_req, mif.stall); end
    tick();
    #3;
    total++; if (mif.stall !== 1'b1 || mif.bus_req !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b want=1/0", mif.stall, mif.bus_req); end
    tick();
    mif.bus_ack   = 1'b1;
    mif.bus_rdata = 32'h0000_0002;
    #3;
    total++; if (mif.bus_req !== 1'b1 || mif.bus_addr !== 32'h64) begin bad++; $display("FAIL b2b_req2 got=%b/%h want=1/00000064", mif.bus_req, mif.bus_addr); end
    tick();
    mif.bus_ack = 1'b0;
    mif.memread = 1'b0;
    #3;
    total++; if (mif.readdata !== 32'h2) begin bad++; $display("FAIL b2b_second_data got=%h want=00000002", mif.readdata); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    mif.memread   = 1'b0;
    mif.memwrite  = 1'b0;
    mif.aluout    = 32'h0;
    mif.writedata = 32'h0;
    mif.bus_ack   = 1'b0;
    mif.bus_rdata = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_both();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
